// File: rtl/text_fetch_pkg.sv
// Shared types and default geometry for the text pixel fetcher: FSM state
// encoding and the tagged beat carried through the output FIFO.
package text_fetch_pkg;

  localparam int TEXT_WIDTH  = 16;
  localparam int TEXT_HEIGHT = 4;
  localparam int CHAR_HEIGHT = 16;

  localparam int DEF_FETCH_LATENCY = 4;
  localparam int DEF_FIFO_DEPTH    = 4;

  localparam int COL_W  = $clog2(TEXT_WIDTH);
  localparam int PROW_W = $clog2(CHAR_HEIGHT);
  localparam int TROW_W = $clog2(TEXT_HEIGHT);
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_ISSUE   = 2'd1,
    FS_WAIT    = 2'd2,
    FS_CAPTURE = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]        char_code;
    logic [7:0]        pixels;
    logic [COL_W-1:0]  col;
    logic [PROW_W-1:0] pixel_row;
    logic [TROW_W-1:0] text_row;
    logic              last;
  } fetch_beat_t;

endpackage

// File: rtl/text_fetch_fifo.sv
// Synchronous FIFO of fetch beats with a combinational head and an occupancy
// count. DEPTH must be a power of two, at least 2.
module text_fetch_fifo
  import text_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  fetch_beat_t            push_data_i,
  input  logic                   pop_i,
  output fetch_beat_t            head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_beat_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push at full is accepted with it.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/text_pixel_fetcher.sv
// Fetches one frame of bytes from the text pixel generator via its toggle
// handshake, tags each with coordinates and queues it. TEXT_FETCH_AUTO_REPEAT_EN loops frames.
module text_pixel_fetcher
  import text_fetch_pkg::*;
#(
  parameter int FETCH_LATENCY = DEF_FETCH_LATENCY,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              toggle_restart,
  output logic              toggle_next,
  input  logic [7:0]        cur_char,
  input  logic [7:0]        cur_pixels,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic [7:0]        out_pixels,
  output logic [COL_W-1:0]  out_col,
  output logic [PROW_W-1:0] out_pixel_row,
  output logic [TROW_W-1:0] out_text_row,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              first_q, first_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PROW_W-1:0] prow_q, prow_d;
  logic [TROW_W-1:0] trow_q, trow_d;
  logic              tog_restart_q, tog_restart_d;
  logic              tog_next_q, tog_next_d;

  logic              col_max;
  logic              prow_max;
  logic              trow_max;
  logic              is_last;
  logic              push;
  fetch_beat_t       push_beat;
  fetch_beat_t       head;
  logic [CNT_W-1:0]  fifo_count;

  assign col_max  = (col_q == COL_W'(TEXT_WIDTH - 1));
  assign prow_max = (prow_q == PROW_W'(CHAR_HEIGHT - 1));
  assign trow_max = (trow_q == TROW_W'(TEXT_HEIGHT - 1));
  assign is_last  = col_max && prow_max && trow_max;

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    wait_d        = wait_q;
    col_d         = col_q;
    prow_d        = prow_q;
    trow_d        = trow_q;
    tog_restart_d = tog_restart_q;
    tog_next_d    = tog_next_q;
    push          = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (frame_start) begin
          first_d = 1'b1;
          col_d   = '0;
          prow_d  = '0;
          trow_d  = '0;
          state_d = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        // Only issue when the resulting capture is sure to find a free slot.
        if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
          if (first_q) tog_restart_d = ~tog_restart_q;
          else         tog_next_d    = ~tog_next_q;
          wait_d  = WAIT_W'(FETCH_LATENCY - 1);
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (wait_q == '0) state_d = FS_CAPTURE;
        else              wait_d  = wait_q - 1'b1;
      end
      FS_CAPTURE: begin
        push = 1'b1;
        if (col_max) begin
          col_d = '0;
          if (prow_max) begin
            prow_d = '0;
            trow_d = trow_max ? '0 : trow_q + 1'b1;
          end else begin
            prow_d = prow_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
        if (is_last) begin
`ifdef TEXT_FETCH_AUTO_REPEAT_EN
          first_d = 1'b1;
          state_d = FS_ISSUE;
`else
          state_d = FS_IDLE;
`endif
        end else begin
          first_d = 1'b0;
          state_d = FS_ISSUE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      first_q       <= 1'b0;
      wait_q        <= '0;
      col_q         <= '0;
      prow_q        <= '0;
      trow_q        <= '0;
      tog_restart_q <= 1'b0;
      tog_next_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      wait_q        <= wait_d;
      col_q         <= col_d;
      prow_q        <= prow_d;
      trow_q        <= trow_d;
      tog_restart_q <= tog_restart_d;
      tog_next_q    <= tog_next_d;
    end
  end

  always_comb begin
    push_beat           = '0;
    push_beat.char_code = cur_char;
    push_beat.pixels    = cur_pixels;
    push_beat.col       = col_q;
    push_beat.pixel_row = prow_q;
    push_beat.text_row  = trow_q;
    push_beat.last      = is_last;
  end

  text_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(push_beat),
    .pop_i      (out_ready),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  assign out_valid      = (fifo_count != '0);
  assign out_char       = head.char_code;
  assign out_pixels     = head.pixels;
  assign out_col        = head.col;
  assign out_pixel_row  = head.pixel_row;
  assign out_text_row   = head.text_row;
  assign out_last       = head.last;

  assign frame_busy     = (state_q != FS_IDLE);
  assign frame_done     = (state_q == FS_CAPTURE) && is_last;
  assign toggle_restart = tog_restart_q;
  assign toggle_next    = tog_next_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_text_pixel_fetcher.sv
// Bench for text_pixel_fetcher: toggle-driven generator model feeding an
// expected-beat queue, popped and compared as the FIFO delivers.
module tb_text_pixel_fetcher;
  import text_fetch_pkg::*;

  localparam int L           = DEF_FETCH_LATENCY;
  localparam int FRAME_BEATS = TEXT_WIDTH * CHAR_HEIGHT * TEXT_HEIGHT;
  localparam int BEAT_W      = $bits(fetch_beat_t);
  localparam int BUDGET      = 20000;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_start;
  logic              frame_busy;
  logic              frame_done;
  logic              toggle_restart;
  logic              toggle_next;
  logic [7:0]        cur_char;
  logic [7:0]        cur_pixels;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic [7:0]        out_pixels;
  logic [COL_W-1:0]  out_col;
  logic [PROW_W-1:0] out_pixel_row;
  logic [TROW_W-1:0] out_text_row;
  logic              out_last;
  logic [1:0]        dbg_state;

  logic [BEAT_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  text_pixel_fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .toggle_restart(toggle_restart),
    .toggle_next   (toggle_next),
    .cur_char      (cur_char),
    .cur_pixels    (cur_pixels),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_char      (out_char),
    .out_pixels    (out_pixels),
    .out_col       (out_col),
    .out_pixel_row (out_pixel_row),
    .out_text_row  (out_text_row),
    .out_last      (out_last),
    .dbg_state     (dbg_state)
  );

  function automatic logic [7:0] gen_char(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [7:0] gen_pix(input int i);
    return 8'(((i >> 2) ^ 8'h3C) & 255);
  endfunction

  function automatic logic [BEAT_W-1:0] make_beat(input int i);
    fetch_beat_t b;
    b.char_code = gen_char(i);
    b.pixels    = gen_pix(i);
    b.col       = COL_W'(i % TEXT_WIDTH);
    b.pixel_row = PROW_W'((i / TEXT_WIDTH) % CHAR_HEIGHT);
    b.text_row  = TROW_W'(i / (TEXT_WIDTH * CHAR_HEIGHT));
    b.last      = (i == FRAME_BEATS - 1);
    return b;
  endfunction

  // ---------------- generator model ----------------
  logic prev_tr = 1'b0;
  logic prev_tn = 1'b0;
  int   gen_idx = 0;
  int   pend = 0;
  int   cyc = 0;
  int   last_edge_cyc = -1000;
  int   restart_edges = 0;
  int   next_edges = 0;
  int   min_gap = 1000000;
  int   same_cycle = 0;
  int   done_pulses = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      prev_tr = 1'b0;
      prev_tn = 1'b0;
      pend    = 0;
      exp_q.delete();
    end else begin
      if (frame_done === 1'b1) done_pulses++;
      if (toggle_restart !== prev_tr || toggle_next !== prev_tn) begin
        if (toggle_restart !== prev_tr && toggle_next !== prev_tn) same_cycle++;
        if (cyc - last_edge_cyc < min_gap) min_gap = cyc - last_edge_cyc;
        last_edge_cyc = cyc;
        if (toggle_restart !== prev_tr) begin
          restart_edges++;
          gen_idx = 0;
        end else begin
          next_edges++;
          gen_idx++;
        end
        prev_tr    = toggle_restart;
        prev_tn    = toggle_next;
        pend       = L;
        cur_char   = 8'($urandom_range(0, 255));
        cur_pixels = 8'($urandom_range(0, 255));
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cur_char   = gen_char(gen_idx);
          cur_pixels = gen_pix(gen_idx);
          exp_q.push_back(make_beat(gen_idx));
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int beats = 0;
  int last_seen = 0;

  always begin
    logic [BEAT_W-1:0] got;
    logic [BEAT_W-1:0] exp;
    @(negedge clk);
    #1;
    if (!reset && out_valid && out_ready) begin
      got = {out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected idx=%0d got=%h expected none", beats, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat idx=%0d got=%h exp=%h", beats, got, exp);
        end
      end
      beats++;
      if (out_last) last_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    restart_edges = 0;
    next_edges    = 0;
    min_gap       = 1000000;
    same_cycle    = 0;
    done_pulses   = 0;
    beats         = 0;
    last_seen     = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    cur_char    = 8'h00;
    cur_pixels  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (toggle_restart !== 1'b0 || toggle_next !== 1'b0) begin
      errors++;
      $display("FAIL reset_toggles got=%b%b exp=00", toggle_restart, toggle_next);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_last got=%b%b exp=00", out_valid, out_last);
    end
    checks++;
    if ({out_char, out_pixels, out_col, out_pixel_row, out_text_row} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0",
               {out_char, out_pixels, out_col, out_pixel_row, out_text_row});
    end
    checks++;
    if (frame_busy !== 1'b0 || frame_done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_status got=%b%b st=%0d exp=00 st=0", frame_busy, frame_done, dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_stats();
  endtask

  task automatic test_single_frame();
    int n = 0;
    clear_stats();
    out_ready = 1'b1;
    pulse_start();
    checks++;
    if (frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got=%b exp=1", frame_busy);
    end
    while ((done_pulses < 1 || out_valid || exp_q.size() != 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL single_timeout got=%0d beats exp=%0d", beats, FRAME_BEATS);
    end
    checks++;
    if (beats != FRAME_BEATS) begin
      errors++;
      $display("FAIL single_beats got=%0d exp=%0d", beats, FRAME_BEATS);
    end
    checks++;
    if (last_seen != 1 || done_pulses != 1) begin
      errors++;
      $display("FAIL single_last_done got last=%0d done=%0d exp 1 1", last_seen, done_pulses);
    end
    checks++;
    if (restart_edges != 1 || next_edges != FRAME_BEATS - 1) begin
      errors++;
      $display("FAIL single_edges got restart=%0d next=%0d exp 1 %0d",
               restart_edges, next_edges, FRAME_BEATS - 1);
    end
    checks++;
    if (min_gap < L + 2 || same_cycle != 0) begin
      errors++;
      $display("FAIL single_toggle_gap got gap=%0d same=%0d exp gap>=%0d same=0",
               min_gap, same_cycle, L + 2);
    end
    checks++;
    if (frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_busy got=%b exp=0", frame_busy);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int edges_before;
    logic [BEAT_W-1:0] head_before;
    clear_stats();
    out_ready = 1'b0;
    pulse_start();
    repeat (120) @(negedge clk);
    checks++;
    if (exp_q.size() != DEF_FIFO_DEPTH || restart_edges + next_edges != DEF_FIFO_DEPTH) begin
      errors++;
      $display("FAIL bp_captured got q=%0d edges=%0d exp=%0d",
               exp_q.size(), restart_edges + next_edges, DEF_FIFO_DEPTH);
    end
    checks++;
    if (dbg_state !== 2'(FS_ISSUE) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got st=%0d valid=%b exp st=%0d valid=1", dbg_state, out_valid, FS_ISSUE);
    end
    edges_before = restart_edges + next_edges;
    head_before  = {out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last};
    pulse_start();
    repeat (30) @(negedge clk);
    checks++;
    if (restart_edges + next_edges != edges_before || restart_edges != 1) begin
      errors++;
      $display("FAIL bp_no_toggle got edges=%0d restart=%0d exp %0d 1",
               restart_edges + next_edges, restart_edges, edges_before);
    end
    checks++;
    if ({out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last} !== head_before) begin
      errors++;
      $display("FAIL bp_head_stable got=%h exp=%h",
               {out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last}, head_before);
    end
    while ((done_pulses < 1 || out_valid || exp_q.size() != 0) && n < BUDGET) begin
      @(negedge clk);
      out_ready   = ($urandom_range(0, 3) != 0);
      frame_start = (n == 2000);
      n++;
    end
    frame_start = 1'b0;
    out_ready   = 1'b1;
    checks++;
    if (n >= BUDGET || beats != FRAME_BEATS) begin
      errors++;
      $display("FAIL bp_beats got=%0d exp=%0d", beats, FRAME_BEATS);
    end
    checks++;
    if (restart_edges != 1 || done_pulses != 1 || last_seen != 1) begin
      errors++;
      $display("FAIL bp_restart_ignored got restart=%0d done=%0d last=%0d exp 1 1 1",
               restart_edges, done_pulses, last_seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    clear_stats();
    out_ready = 1'b1;
    pulse_start();
    while (beats < 300 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || toggle_restart !== 1'b0 || toggle_next !== 1'b0 ||
        frame_busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got v=%b tr=%b tn=%b busy=%b done=%b exp all 0",
               out_valid, toggle_restart, toggle_next, frame_busy, frame_done);
    end
    checks++;
    if ({out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last} !== '0 ||
        dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_data got=%h st=%0d exp=0 st=0",
               {out_char, out_pixels, out_col, out_pixel_row, out_text_row, out_last}, dbg_state);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_pulses != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abandon got done=%0d valid=%b exp 0 0", done_pulses, out_valid);
    end
    clear_stats();
    n = 0;
    pulse_start();
    while ((done_pulses < 1 || out_valid || exp_q.size() != 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BUDGET || beats != FRAME_BEATS || done_pulses != 1) begin
      errors++;
      $display("FAIL midreset_refetch got beats=%0d done=%0d exp %0d 1", beats, done_pulses, FRAME_BEATS);
    end
    checks++;
    if (restart_edges != 1 || next_edges != FRAME_BEATS - 1) begin
      errors++;
      $display("FAIL midreset_edges got restart=%0d next=%0d exp 1 %0d",
               restart_edges, next_edges, FRAME_BEATS - 1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
